// File: rtl/axi_fft_pkg.sv
// Shared constants and state type for the AXI-Lite FFT peripheral driver.
package axi_fft_pkg;

  localparam logic [15:0] OFF_FFT_CONFIG  = 16'h0010;
  localparam logic [15:0] OFF_STATUS      = 16'h0014;
  localparam logic [15:0] OFF_RESET       = 16'h0080;
  localparam logic [15:0] OFF_INPUT_TRIG  = 16'h0084;
  localparam logic [15:0] OFF_CONFIG_TRIG = 16'h0088;
  localparam logic [15:0] OFF_DATA        = 16'h0100;

  localparam logic [1:0]  RESP_OKAY       = 2'b00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_WR,
    ST_CFG_TRIG,
    ST_LOAD_WAIT,
    ST_LOAD_RE,
    ST_LOAD_IM,
    ST_IN_TRIG,
    ST_POLL_GAP,
    ST_POLL_RD,
    ST_UNLOAD_RE,
    ST_UNLOAD_IM,
    ST_EMIT,
    ST_PERIPH_RST
  } fft_state_e;

endpackage

// File: rtl/axi_fft_lite_xfer.sv
// Single-outstanding AXI4-Lite transaction engine. A held req starts one
// transaction when idle; done pulses in the cycle the response handshakes.
module axi_fft_lite_xfer
  import axi_fft_pkg::*;
(
  input  logic        up_clk,
  input  logic        up_rstn,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [15:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [15:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp
);

  logic        active;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic        done_w;
  logic        done_r;

  assign done_w = m_axi_bready & m_axi_bvalid;
  assign done_r = m_axi_rready & m_axi_rvalid;

  // Issue on req when idle; each channel valid drops on its own ready.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      active        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      if (req && !active) begin
        active  <= 1'b1;
        addr_q  <= addr;
        wdata_q <= wdata;
        if (we) begin
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
          m_axi_bready  <= 1'b1;
        end else begin
          m_axi_arvalid <= 1'b1;
          m_axi_rready  <= 1'b1;
        end
      end
      if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
      if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
      if (done_w) begin
        m_axi_bready <= 1'b0;
        active       <= 1'b0;
      end
      if (done_r) begin
        m_axi_rready <= 1'b0;
        active       <= 1'b0;
      end
    end
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = '1;
  assign m_axi_awprot = '0;
  assign m_axi_arprot = '0;

  assign done     = done_w | done_r;
  assign rdata    = m_axi_rdata;
  assign resp_err = (done_w && (m_axi_bresp != RESP_OKAY)) ||
                    (done_r && (m_axi_rresp != RESP_OKAY));

endmodule

// File: rtl/axi_fft_driver.sv
// Streams a frame of complex samples into the FFT peripheral over AXI-Lite,
// triggers it, polls STATUS[0] and streams the result bins back out.
// Optional: AXI_FFT_DRIVER_POLL_TIMEOUT_EN bounds polling by TIMEOUT_CYCLES.
module axi_fft_driver
  import axi_fft_pkg::*;
#(
  parameter int          NFFT           = 3,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          POLL_GAP       = 8,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [15:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [15:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [63:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [63:0] m_axis_tdata,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_data,
  output logic        busy,
  output logic        err
);

  localparam int          POINTS   = 2 ** NFFT;
  localparam int          GAP_W    = ($clog2(POLL_GAP + 1) > 4) ? $clog2(POLL_GAP + 1) : 4;
  localparam logic [15:0] BASE     = BASE_ADDR[15:0];
  localparam logic [15:0] IN_BASE  = BASE + OFF_DATA;
  localparam logic [15:0] OUT_BASE = 16'(BASE + OFF_DATA + 16'(8 * POINTS));
  localparam fft_state_e  GAP_ENTRY = (POLL_GAP == 0) ? ST_POLL_RD : ST_POLL_GAP;

  fft_state_e        state, state_nxt;
  logic [NFFT-1:0]   k;
  logic [15:0]       k_off;
  logic              k_last;
  logic              cfg_pending;
  logic [31:0]       cfg_word;
  logic [63:0]       sample;
  logic [31:0]       out_re, out_im;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tmo_hit;

  logic              req, we;
  logic [15:0]       xaddr;
  logic [31:0]       xwdata;
  logic              xdone;
  logic [31:0]       xrdata;
  logic              xresp_err;

  assign k_off  = 16'({k, 3'b000});
  assign k_last = (k == '1);

`ifdef AXI_FFT_DRIVER_POLL_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Count cycles spent polling; saturates once the budget is reached.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn)                                     tmo_cnt <= '0;
    else if (state == ST_IN_TRIG)                           tmo_cnt <= '0;
    else if ((state == ST_POLL_GAP || state == ST_POLL_RD) && !tmo_hit)
                                                            tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Next state and the request presented to the AXI-Lite engine.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    we        = 1'b0;
    xaddr     = BASE;
    xwdata    = '0;
    case (state)
      ST_IDLE:
        if (s_axis_tvalid) state_nxt = cfg_pending ? ST_CFG_WR : ST_LOAD_WAIT;
      ST_CFG_WR: begin
        req = 1'b1; we = 1'b1; xaddr = BASE + OFF_FFT_CONFIG; xwdata = cfg_word;
        if (xdone) state_nxt = ST_CFG_TRIG;
      end
      ST_CFG_TRIG: begin
        req = 1'b1; we = 1'b1; xaddr = BASE + OFF_CONFIG_TRIG; xwdata = 32'd1;
        if (xdone) state_nxt = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT:
        if (s_axis_tvalid) state_nxt = ST_LOAD_RE;
      ST_LOAD_RE: begin
        req = 1'b1; we = 1'b1; xaddr = IN_BASE + k_off; xwdata = sample[31:0];
        if (xdone) state_nxt = ST_LOAD_IM;
      end
      ST_LOAD_IM: begin
        req = 1'b1; we = 1'b1; xaddr = IN_BASE + k_off + 16'd4; xwdata = sample[63:32];
        if (xdone) state_nxt = k_last ? ST_IN_TRIG : ST_LOAD_WAIT;
      end
      ST_IN_TRIG: begin
        req = 1'b1; we = 1'b1; xaddr = BASE + OFF_INPUT_TRIG; xwdata = 32'd1;
        if (xdone) state_nxt = GAP_ENTRY;
      end
      ST_POLL_GAP:
        if (tmo_hit)                             state_nxt = ST_PERIPH_RST;
        else if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_nxt = ST_POLL_RD;
      ST_POLL_RD: begin
        req = 1'b1; xaddr = BASE + OFF_STATUS;
        if (xdone) begin
          if (xrdata[0])    state_nxt = ST_UNLOAD_RE;
          else if (tmo_hit) state_nxt = ST_PERIPH_RST;
          else              state_nxt = GAP_ENTRY;
        end
      end
      ST_UNLOAD_RE: begin
        req = 1'b1; xaddr = OUT_BASE + k_off;
        if (xdone) state_nxt = ST_UNLOAD_IM;
      end
      ST_UNLOAD_IM: begin
        req = 1'b1; xaddr = OUT_BASE + k_off + 16'd4;
        if (xdone) state_nxt = ST_EMIT;
      end
      ST_EMIT:
        if (m_axis_tready) state_nxt = k_last ? ST_IDLE : ST_UNLOAD_RE;
      ST_PERIPH_RST: begin
        req = 1'b1; we = 1'b1; xaddr = BASE + OFF_RESET; xwdata = 32'd0;
        if (xdone) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Point index, captured data, pending config and sticky error.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      k           <= '0;
      cfg_pending <= 1'b0;
      cfg_word    <= '0;
      sample      <= '0;
      out_re      <= '0;
      out_im      <= '0;
      gap_cnt     <= '0;
      err         <= 1'b0;
    end else begin
      if (cfg_valid) begin
        cfg_word    <= cfg_data;
        cfg_pending <= 1'b1;
      end else if (state == ST_CFG_TRIG && xdone) begin
        cfg_pending <= 1'b0;
      end
      if (xresp_err) err <= 1'b1;
      case (state)
        ST_IDLE:      k <= '0;
        ST_LOAD_WAIT:
          if (s_axis_tvalid) begin
            sample <= s_axis_tdata;
            if (s_axis_tlast != k_last) err <= 1'b1;
          end
        ST_LOAD_IM:   if (xdone) k <= k + 1'b1;
        ST_IN_TRIG:   gap_cnt <= '0;
        ST_POLL_GAP:  gap_cnt <= gap_cnt + 1'b1;
        ST_POLL_RD:
          if (xdone) begin
            gap_cnt <= '0;
            k       <= '0;
          end
        ST_UNLOAD_RE: if (xdone) out_re <= xrdata;
        ST_UNLOAD_IM: if (xdone) out_im <= xrdata;
        ST_EMIT:      if (m_axis_tready) k <= k + 1'b1;
        ST_PERIPH_RST: err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign s_axis_tready = (state == ST_LOAD_WAIT) && s_axis_tvalid;
  assign m_axis_tvalid = (state == ST_EMIT);
  assign m_axis_tlast  = (state == ST_EMIT) && k_last;
  assign m_axis_tdata  = {out_im, out_re};
  assign busy          = (state != ST_IDLE);

  axi_fft_lite_xfer u_xfer (
    .up_clk        (m_axi_aclk),
    .up_rstn       (m_axi_aresetn),
    .req           (req),
    .we            (we),
    .addr          (xaddr),
    .wdata         (xwdata),
    .done          (xdone),
    .rdata         (xrdata),
    .resp_err      (xresp_err),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp)
  );

endmodule

// File: tb/tb_axi_fft_driver.sv
// Directed bench for axi_fft_driver: AXI-Lite peripheral model with optional
// random ready/response delays, AXIS source and sink, transaction log check.
module tb_axi_fft_driver;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk, rstn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        busy, err;

  int total = 0;
  int bad   = 0;

  axi_fft_driver #(
    .NFFT           (3),
    .BASE_ADDR      (32'h0),
    .POLL_GAP       (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rstn),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_awaddr  (awaddr),
    .m_axi_awprot  (awprot),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_bresp   (bresp),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_araddr  (araddr),
    .m_axi_arprot  (arprot),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tdata  (m_tdata),
    .cfg_valid     (cfg_valid),
    .cfg_data      (cfg_data),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic w, input logic [15:0] a, input logic [31:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.data = d;
    return t;
  endfunction

  // ---------------- peripheral model ----------------
  bit          rnd = 1'b0;
  int          polls_needed = 3;
  int          err_read_idx = -1;
  int          st_reads;
  int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          aw_got, w_got, ar_got;
  logic [15:0] aw_a, ar_a;
  logic [31:0] w_d;
  logic [31:0] out_mem [16];
  txn_t        tlog [$];
  txn_t        exp_log [$];
  logic [64:0] oq [$];

  function automatic int unsigned dly();
    return rnd ? $urandom_range(0, 5) : 0;
  endfunction

  assign awready = (aw_cnt == 0);
  assign wready  = (w_cnt == 0);
  assign arready = (ar_cnt == 0);

  always @(posedge clk) begin
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      bvalid <= 0; rvalid <= 0; bresp <= 0; rresp <= 0; rdata <= 0;
      st_reads <= 0;
    end else begin
      if (awvalid && awready) begin aw_got <= 1; aw_a <= awaddr; aw_cnt <= dly(); end
      else if (aw_cnt != 0) aw_cnt <= aw_cnt - 1;
      if (wvalid && wready) begin w_got <= 1; w_d <= wdata; w_cnt <= dly(); end
      else if (w_cnt != 0) w_cnt <= w_cnt - 1;
      if (aw_got && w_got && !bvalid) begin
        if (b_cnt == 0) begin
          bvalid <= 1; bresp <= 2'b00;
          tlog.push_back(mk(1'b1, aw_a, w_d));
          if (aw_a == 16'h0084) st_reads <= 0;
        end else b_cnt <= b_cnt - 1;
      end
      if (bvalid && bready) begin bvalid <= 0; aw_got <= 0; w_got <= 0; b_cnt <= dly(); end

      if (arvalid && arready) begin ar_got <= 1; ar_a <= araddr; ar_cnt <= dly(); end
      else if (ar_cnt != 0) ar_cnt <= ar_cnt - 1;
      if (ar_got && !rvalid) begin
        if (r_cnt == 0) begin
          rvalid <= 1; rresp <= 2'b00; rdata <= 32'h0;
          tlog.push_back(mk(1'b0, ar_a, 32'h0));
          if (ar_a == 16'h0014) begin
            st_reads <= st_reads + 1;
            rdata <= {31'b0, (st_reads + 1 >= polls_needed)};
            if (st_reads == err_read_idx) rresp <= 2'b10;
          end else if (ar_a >= 16'h0140 && ar_a < 16'h0180) begin
            rdata <= out_mem[ar_a[5:2]];
          end
        end else r_cnt <= r_cnt - 1;
      end
      if (rvalid && rready) begin rvalid <= 0; ar_got <= 0; r_cnt <= dly(); end
    end
  end

  // Output sink: ready 30% of cycles in random mode; log each accepted beat.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(negedge clk);
      m_tready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (m_tvalid && m_tready) oq.push_back({m_tlast, m_tdata});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] tlast_bits);
    int n;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = {32'(-k), 32'(k)};
      s_tlast  = tlast_bits[k];
      #1;
      n = 0;
      while (!s_tready && n < 2000) begin @(negedge clk); #1; n++; end
      if (n >= 2000) check_eq("tready_wait", 64'(n), 64'(0));
      @(posedge clk);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic build_exp(input bit cfg, input int polls);
    exp_log.delete();
    if (cfg) begin
      exp_log.push_back(mk(1'b1, 16'h0010, 32'h0000_000B));
      exp_log.push_back(mk(1'b1, 16'h0088, 32'h1));
    end
    for (int e = 0; e < 16; e++)
      exp_log.push_back(mk(1'b1, 16'(16'h0100 + 4 * e), (e % 2 == 0) ? 32'(e / 2) : 32'(-(e / 2))));
    exp_log.push_back(mk(1'b1, 16'h0084, 32'h1));
    for (int i = 0; i < polls; i++) exp_log.push_back(mk(1'b0, 16'h0014, 32'h0));
    for (int e = 0; e < 16; e++) exp_log.push_back(mk(1'b0, 16'(16'h0140 + 4 * e), 32'h0));
  endtask

  task automatic run_frame(input string tag, input bit cfg, input logic [7:0] tlast_bits);
    int n;
    oq.delete();
    tlog.delete();
    if (cfg) begin
      @(negedge clk); cfg_valid = 1'b1; cfg_data = 32'h0000_000B;
      @(negedge clk); cfg_valid = 1'b0;
    end
    send_frame(tlast_bits);
    n = 0;
    while ((busy || oq.size() < 8) && n < 20000) begin @(negedge clk); n++; end
    check_eq({tag, "_finished"}, 64'(n < 20000), 64'(1));
    build_exp(cfg, 3);
    check_eq({tag, "_txn_count"}, 64'(tlog.size()), 64'(exp_log.size()));
    for (int i = 0; i < tlog.size() && i < exp_log.size(); i++)
      check_eq($sformatf("%s_txn[%0d]", tag, i), 64'(tlog[i]), 64'(exp_log[i]));
    check_eq({tag, "_beats"}, 64'(oq.size()), 64'(8));
    for (int k = 0; k < oq.size() && k < 8; k++) begin
      check_eq($sformatf("%s_tdata[%0d]", tag, k), oq[k][63:0], {out_mem[2*k+1], out_mem[2*k]});
      check_eq($sformatf("%s_tlast[%0d]", tag, k), 64'(oq[k][64]), 64'(k == 7));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    cfg_data = 32'h0;
    s_tdata  = 64'h0;
    for (int e = 0; e < 16; e++) out_mem[e] = 32'h5A00_0000 + 32'(e) * 32'h0000_0101;

    do_reset();
    check_eq("rst_busy",    64'(busy),     64'(0));
    check_eq("rst_err",     64'(err),      64'(0));
    check_eq("rst_awvalid", 64'(awvalid),  64'(0));
    check_eq("rst_wvalid",  64'(wvalid),   64'(0));
    check_eq("rst_arvalid", 64'(arvalid),  64'(0));
    check_eq("rst_bready",  64'(bready),   64'(0));
    check_eq("rst_rready",  64'(rready),   64'(0));
    check_eq("rst_s_tready",64'(s_tready), 64'(0));
    check_eq("rst_m_tvalid",64'(m_tvalid), 64'(0));
    check_eq("wstrb",       64'(wstrb),    64'(4'hF));

    run_frame("plain", 1'b0, 8'h80);
    check_eq("plain_err", 64'(err), 64'(0));

    run_frame("cfg", 1'b1, 8'h80);
    rnd = 1'b1;
    run_frame("nocfg_rnd", 1'b0, 8'h80);
    rnd = 1'b0;
    check_eq("cfg_err", 64'(err), 64'(0));

    do_reset();
    run_frame("tlast3", 1'b0, 8'h08);
    check_eq("tlast3_err", 64'(err), 64'(1));

    do_reset();
    err_read_idx = 1;
    run_frame("rresp", 1'b0, 8'h80);
    check_eq("rresp_err", 64'(err), 64'(1));
    err_read_idx = -1;

`ifdef AXI_FFT_DRIVER_POLL_TIMEOUT_EN
    do_reset();
    polls_needed = 1000;
    oq.delete();
    tlog.delete();
    send_frame(8'h80);
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check_eq("tmo_finished", 64'(n < 5000), 64'(1));
    check_eq("tmo_busy", 64'(busy), 64'(0));
    check_eq("tmo_err", 64'(err), 64'(1));
    check_eq("tmo_beats", 64'(oq.size()), 64'(0));
    check_eq("tmo_txn_count_ok", 64'(tlog.size() > 18), 64'(1));
    if (tlog.size() > 18) begin
      check_eq("tmo_trig_txn", 64'(tlog[16]), 64'(mk(1'b1, 16'h0084, 32'h1)));
      check_eq("tmo_last_txn", 64'(tlog[tlog.size() - 1]), 64'(mk(1'b1, 16'h0080, 32'h0)));
    end
    polls_needed = 3;
`endif

    // Reset asserted between clock edges while the first load write is in flight.
    do_reset();
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 64'h0; s_tlast = 1'b0;
    n = 0;
    while (!awvalid && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("load_started", 64'(awvalid), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_awvalid", 64'(awvalid),  64'(0));
    check_eq("arst_wvalid",  64'(wvalid),   64'(0));
    check_eq("arst_bready",  64'(bready),   64'(0));
    check_eq("arst_busy",    64'(busy),     64'(0));
    check_eq("arst_s_tready",64'(s_tready), 64'(0));
    check_eq("arst_m_tvalid",64'(m_tvalid), 64'(0));
    s_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
